// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_CPU = 2'd1,
    ST_GNT_EXT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU and external ports.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority; default is round-robin.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic i_cpu_elig,
  input  logic i_ext_elig,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  logic w_tie_winner;

`ifdef DMEM_ARB_CPU_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last_grant;
  assign w_tie_winner  = PORT_CPU;
`else
  // On a tie, the port that did not win last time goes next.
  assign w_tie_winner = (i_last_grant == PORT_EXT) ? PORT_CPU : PORT_EXT;
`endif

  always_comb begin
    o_valid  = i_cpu_elig | i_ext_elig;
    o_winner = PORT_CPU;
    if (i_cpu_elig && i_ext_elig) begin
      o_winner = w_tie_winner;
    end else if (i_ext_elig) begin
      o_winner = PORT_EXT;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / external loader) arbiter for the single data-memory port.
// Round-robin by default; DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_cpu_ack;
  logic              r_ext_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ext_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;

  logic w_cpu_elig;
  logic w_ext_elig;
  logic w_valid;
  logic w_winner;

  // A port is masked in its own ack cycle so a held request is not re-granted.
  assign w_cpu_elig = cpu_req & ~r_cpu_ack;
  assign w_ext_elig = ext_req & ~r_ext_ack;

  dmem_arb_pick u_pick (
    .i_cpu_elig  (w_cpu_elig),
    .i_ext_elig  (w_ext_elig),
    .i_last_grant(r_last_grant),
    .o_valid     (w_valid),
    .o_winner    (w_winner)
  );

  // Memory-port registers are loaded on the edge entering a grant so they
  // are valid throughout the grant cycle; read data is captured on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_EXT;
      r_cpu_ack    <= 1'b0;
      r_ext_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_ext_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            if (w_winner == PORT_EXT) begin
              r_mem_addr  <= ext_addr;
              r_mem_wdata <= ext_wdata;
              r_mem_we    <= ext_we;
              r_state     <= ST_GNT_EXT;
            end else begin
              r_mem_addr  <= cpu_addr;
              r_mem_wdata <= cpu_wdata;
              r_mem_we    <= cpu_we;
              r_state     <= ST_GNT_CPU;
            end
          end
        end
        ST_GNT_CPU: begin
          r_cpu_rdata  <= mem_rdata;
          r_cpu_ack    <= 1'b1;
          r_last_grant <= PORT_CPU;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_mem_we     <= 1'b0;
          r_state      <= ST_IDLE;
        end
        ST_GNT_EXT: begin
          r_ext_rdata  <= mem_rdata;
          r_ext_ack    <= 1'b1;
          r_last_grant <= PORT_EXT;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_mem_we     <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_we    <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign ext_ack   = r_ext_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign ext_rdata = r_ext_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default round-robin build).
module tb_dmem_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [32];

  int n_checks;
  int n_fail;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req  (ext_req),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_wdata(ext_wdata),
    .ext_ack  (ext_ack),
    .ext_rdata(ext_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Alternation table for both ports held: mem_addr, cpu_ack, ext_ack per cycle.
  logic [4:0] alt_addr [8];
  logic       alt_cack [8];
  logic       alt_eack [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int unsigned i = 0; i < 32; i++) mem[i] = '0;
    mem[3] = 32'd14;
    mem[5] = 32'd55;

    alt_addr = '{5'd3, 5'd0, 5'd8, 5'd0, 5'd3, 5'd0, 5'd8, 5'd0};
    alt_cack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    alt_eack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    tick();
    tick();
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ext_ack", 32'(ext_ack), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_ext_rdata", ext_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // CPU load addr 3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    #1;
    check("ld_stall_c0", 32'(cpu_stall), 32'd1);
    tick();
    check("ld_gnt_addr", 32'(mem_addr), 32'd3);
    check("ld_gnt_we", 32'(mem_we), 32'd0);
    check("ld_stall_c1", 32'(cpu_stall), 32'd1);
    check("ld_ack_early", 32'(cpu_ack), 32'd0);
    tick();
    check("ld_ack", 32'(cpu_ack), 32'd1);
    check("ld_rdata", cpu_rdata, 32'd14);
    check("ld_stall_c2", 32'(cpu_stall), 32'd0);
    check("ld_idle_addr", 32'(mem_addr), 32'd0);
    cpu_req = 1'b0;
    tick();
    check("ld_ack_pulse", 32'(cpu_ack), 32'd0);
    check("ld_rdata_hold", cpu_rdata, 32'd14);

    // Ext store then load addr 8
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd8; ext_wdata = 32'hDEADBEEF;
    tick();
    check("st_gnt_we", 32'(mem_we), 32'd1);
    check("st_gnt_addr", 32'(mem_addr), 32'd8);
    check("st_gnt_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    check("st_ack", 32'(ext_ack), 32'd1);
    check("st_we_drop", 32'(mem_we), 32'd0);
    ext_req = 1'b0; ext_we = 1'b0;
    tick();
    ext_req = 1'b1;
    tick();
    check("ext_ld_we", 32'(mem_we), 32'd0);
    check("ext_ld_addr", 32'(mem_addr), 32'd8);
    tick();
    check("ext_ld_ack", 32'(ext_ack), 32'd1);
    check("ext_ld_rdata", ext_rdata, 32'hDEADBEEF);
    ext_req = 1'b0;
    tick();

    // Reset, then both request together: CPU first, then alternation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd8;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("alt_addr_c%0d", i + 1), 32'(mem_addr), 32'(alt_addr[i]));
      check($sformatf("alt_cack_c%0d", i + 1), 32'(cpu_ack), 32'(alt_cack[i]));
      check($sformatf("alt_eack_c%0d", i + 1), 32'(ext_ack), 32'(alt_eack[i]));
      if (i == 6) begin
        cpu_req = 1'b0;
        ext_req = 1'b0;
      end
    end
    check("alt_cpu_rdata", cpu_rdata, 32'd14);
    check("alt_ext_rdata", ext_rdata, 32'hDEADBEEF);
    tick();

    // Held request through ack: no grant in the ack cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    tick();
    check("hold_gnt1", 32'(mem_addr), 32'd5);
    tick();
    check("hold_ack1", 32'(cpu_ack), 32'd1);
    check("hold_rdata", cpu_rdata, 32'd55);
    tick();
    check("hold_nodup_addr", 32'(mem_addr), 32'd0);
    check("hold_nodup_ack", 32'(cpu_ack), 32'd0);
    check("hold_stall", 32'(cpu_stall), 32'd1);
    tick();
    check("hold_gnt2", 32'(mem_addr), 32'd5);
    cpu_req = 1'b0;
    tick();
    check("hold_ack2", 32'(cpu_ack), 32'd1);
    tick();

    // Reset during an ext store grant
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd10; ext_wdata = 32'h12345678;
    tick();
    check("rstg_we_before", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstg_we_async", 32'(mem_we), 32'd0);
    check("rstg_addr_async", 32'(mem_addr), 32'd0);
    check("rstg_ack_async", 32'(ext_ack), 32'd0);
    ext_req = 1'b0; ext_we = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstg_noack_%0d", i), 32'(ext_ack), 32'd0);
    end
    check("rstg_no_write", mem[10], 32'd0);
    cpu_req = 1'b1; cpu_addr = 5'd3;
    tick();
    check("rstg_idle_gnt", 32'(mem_addr), 32'd3);
    cpu_req = 1'b0;
    tick();
    check("rstg_idle_ack", 32'(cpu_ack), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
